// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: idle pin levels and
// active-high glyphs (bit order g..a) for hex codes 0-F.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex code to active-high seven-segment glyph (g..a).
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_0;
        unique case (code)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with inter-digit blanking and
// frame-coherent capture. Optional digit blinking is built when SEG_BLINK_EN is defined.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic [3:0]  dp,
    input  logic [3:0]  blink_mask,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYC);

    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        idx;
    logic [15:0]       snap_digits;
    logic [3:0]        snap_dp;
    logic              slot_wrap;
    logic              capture;
    logic [6:0]        glyph;
    logic              dark;

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign capture   = slot_wrap && (idx == 2'd3);

    seg_hex_decoder u_dec (
        .code  (snap_digits[idx*4 +: 4]),
        .glyph (glyph)
    );

`ifdef SEG_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [3:0]         snap_blink;

    // Free-running, independent of the scan so blink rate is set by BLINK_DIV alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            snap_blink  <= 4'h0;
        end else begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
            if (capture)
                snap_blink <= blink_mask;
        end
    end

    assign dark = blink_phase & snap_blink[idx];
`else
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask;
    assign dark = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            idx         <= 2'd0;
            snap_digits <= 16'h0000;
            snap_dp     <= 4'h0;
            seg         <= SEG_BLANK;
            an          <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            if (slot_wrap) begin
                slot_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end

            if (capture) begin
                snap_digits <= digits;
                snap_dp     <= dp;
            end
            frame_start <= capture;

            // Every idx change lands inside a blank window, so anodes never overlap.
            if (slot_cnt < BLANK_END) begin
                seg <= SEG_BLANK;
                an  <= AN_OFF;
            end else begin
                an  <= ~(4'b0001 << idx);
                seg <= dark ? SEG_BLANK : {~snap_dp[idx], ~glyph};
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver against a cycle-count based reference model.
module tb_seg_scan_driver;

    localparam int R = 8;
    localparam int B = 2;
    localparam int K = 64;
    localparam int FRAME = 4 * R;

    localparam logic [6:0] TB_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blink_mask;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          cnt;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    logic [3:0]  m_blk;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_fs;
    int          blank_run;
    logic [3:0]  last_lit;

    always #5 clk = ~clk;

    seg_scan_driver #(.REFRESH_DIV(R), .BLANK_CYC(B), .BLINK_DIV(K)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits      (digits),
        .dp          (dp),
        .blink_mask  (blink_mask),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cnt);
        end
    endtask

    task automatic model_reset();
        cnt       = 0;
        m_dig     = 16'h0;
        m_dp      = 4'h0;
        m_blk     = 4'h0;
        blank_run = 0;
        last_lit  = 4'hF;
    endtask

    // Expected pins after the edge that leaves cycle number cnt since reset release.
    task automatic model_step();
        int  slot, d;
        logic blk_on;
        slot   = cnt % R;
        d      = (cnt / R) % 4;
        blk_on = 1'b0;
`ifdef SEG_BLINK_EN
        blk_on = (((cnt / K) % 2) == 1) && m_blk[d];
`endif
        if (slot < B) begin
            exp_an  = 4'hF;
            exp_seg = 8'hFF;
        end else begin
            exp_an  = 4'hF;
            exp_an[d] = 1'b0;
            exp_seg = blk_on ? 8'hFF : {~m_dp[d], ~TB_GLYPH[m_dig[d*4 +: 4]]};
        end
        exp_fs = ((cnt % FRAME) == FRAME - 1);
        if (exp_fs) begin
            m_dig = digits;
            m_dp  = dp;
            m_blk = blink_mask;
        end
        cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("seg", seg, exp_seg);
            check("an", an, exp_an);
            check("frame_start", frame_start, exp_fs);
            check("an_onehot", (an == 4'hF || $countones(~an) == 1), 1);
            if (an == 4'hF) begin
                blank_run++;
            end else begin
                if (last_lit != 4'hF && an != last_lit)
                    check("blank_gap", (blank_run >= B), 1);
                last_lit  = an;
                blank_run = 0;
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        digits     = 16'h0;
        dp         = 4'h0;
        blink_mask = 4'h0;
        model_reset();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_seg", seg, 8'hFF);
        check("rst_an", an, 4'hF);
        check("rst_fs", frame_start, 0);
        rst_n = 1'b1;

        // first lit slot shows "0" from the cleared snapshot
        run(3);
        check("first_lit_an", an, 4'b1110);
        check("first_lit_seg", seg, {1'b1, ~7'h3F});

        digits = 16'h1234;
        dp     = 4'b0100;
        run(2 * FRAME);

        // change mid-frame while slot idx is 1; must not tear
        while ((cnt % FRAME) != R + 3) run(1);
        digits = 16'h9999;
        run(FRAME + FRAME / 2);

        // 5-frame steady run
        run(5 * FRAME);

        digits = 16'hABCF;
        dp     = 4'b0000;
        run(FRAME + 5);

        // async reset mid-slot
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_seg", seg, 8'hFF);
        check("async_rst_an", an, 4'hF);
        check("async_rst_fs", frame_start, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run(2 * FRAME);

`ifdef SEG_BLINK_EN
        blink_mask = 4'b0001;
        digits     = 16'h5678;
        run(5 * K);
        blink_mask = 4'h0;
`endif

        for (int t = 0; t < 12; t++) begin
            digits     = 16'($urandom);
            dp         = 4'($urandom);
            blink_mask = 4'($urandom);
            run($urandom_range(5, 50));
        end
        run(2 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
